// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing generator and the image
// generator that feeds it.
//   - default 640x480@60 Hz timing constants (25 MHz pixel clock) and the
//     resulting line/frame totals
//   - PIX_INVALID, the coordinate value driven when no pixel is requested
//   - RGB565 colour constants
//   - in_range(), an inclusive window compare used by the timing decode
package vga_pkg;

  localparam logic [9:0] H_SYNC_DEF  = 10'd96;
  localparam logic [9:0] H_BACK_DEF  = 10'd48;
  localparam logic [9:0] H_VALID_DEF = 10'd640;
  localparam logic [9:0] H_FRONT_DEF = 10'd16;
  localparam logic [9:0] V_SYNC_DEF  = 10'd2;
  localparam logic [9:0] V_BACK_DEF  = 10'd33;
  localparam logic [9:0] V_VALID_DEF = 10'd480;
  localparam logic [9:0] V_FRONT_DEF = 10'd10;

  localparam logic [9:0] H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF + H_FRONT_DEF; // 800
  localparam logic [9:0] V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF + V_FRONT_DEF; // 525

  localparam logic [9:0] PIX_INVALID = 10'h3ff;

  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = 16'hffff;
  localparam logic [15:0] RGB_RED   = 16'hf800;
  localparam logic [15:0] RGB_GREEN = 16'h07e0;
  localparam logic [15:0] RGB_BLUE  = 16'h001f;

  // Inclusive window test: lo <= val <= hi.
  function automatic logic in_range(input logic [9:0] val,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_scan_cnt.sv
// vga_scan_cnt: modulo-N up counter with enable and wrap flag.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears cnt to 0
//   en   - count enable
//   cnt  - current count, 0..N-1
//   wrap - high while en is set and cnt = N-1 (the count returns to 0 on
//          the next edge); usable as the enable of a cascaded counter
module vga_scan_cnt #(
  parameter int unsigned W = 10,
  parameter int unsigned N = 800
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing generator (default 640x480@60 Hz, 25 MHz pixel clock).
// Owns the horizontal/vertical scan counters, decodes hsync/vsync, requests
// pixels one cycle ahead of the visible region and gates the returned pixel
// onto rgb during active video.
// Ports:
//   clk         - pixel clock
//   rst         - synchronous active-high reset; counters return to (0,0)
//   pix_data    - RGB565 pixel returned by the image generator
//   pix_x/pix_y - requested column/row, PIX_INVALID when no request
//   hsync/vsync - active-high sync pulses, decoded from the counters
//   rgb         - displayed pixel, black outside active video
//   frame_start - one-cycle pulse while the counters sit at (0,0) after a
//                 full frame (not after reset)
//   frame_cnt   - 8-bit frame counter, only with VGA_CTRL_FRAME_CNT_EN defined
//
// Pixel request protocol: there is no valid/ready pair. A request is "valid"
// whenever pix_x/pix_y differ from PIX_INVALID; the image generator must
// accept every request and return its pixel on pix_data exactly one cycle
// later (registered on its side). The timing generator never stalls.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter logic [9:0] H_SYNC  = H_SYNC_DEF,
  parameter logic [9:0] H_BACK  = H_BACK_DEF,
  parameter logic [9:0] H_VALID = H_VALID_DEF,
  parameter logic [9:0] H_FRONT = H_FRONT_DEF,
  parameter logic [9:0] V_SYNC  = V_SYNC_DEF,
  parameter logic [9:0] V_BACK  = V_BACK_DEF,
  parameter logic [9:0] V_VALID = V_VALID_DEF,
  parameter logic [9:0] V_FRONT = V_FRONT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        frame_start
`ifdef VGA_CTRL_FRAME_CNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);

  localparam int unsigned LINE_LEN  = 32'(H_SYNC) + 32'(H_BACK) + 32'(H_VALID) + 32'(H_FRONT);
  localparam int unsigned FRAME_LEN = 32'(V_SYNC) + 32'(V_BACK) + 32'(V_VALID) + 32'(V_FRONT);

  // Active video window in counter coordinates.
  localparam logic [9:0] H_ACT_START = H_SYNC + H_BACK;
  localparam logic [9:0] H_ACT_END   = H_ACT_START + H_VALID - 10'd1;
  localparam logic [9:0] V_ACT_START = V_SYNC + V_BACK;
  localparam logic [9:0] V_ACT_END   = V_ACT_START + V_VALID - 10'd1;
  // Requests lead the visible window by one pixel to cover the generator's
  // one-cycle return latency.
  localparam logic [9:0] H_REQ_START = H_ACT_START - 10'd1;
  localparam logic [9:0] H_REQ_END   = H_ACT_END - 10'd1;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       v_act;
  logic       rgb_valid;
  logic       pix_req;

  vga_scan_cnt #(.W(10), .N(LINE_LEN)) u_h_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  // v_wrap already includes h_wrap (it is this counter's enable), so it
  // marks the last pixel of the frame.
  vga_scan_cnt #(.W(10), .N(FRAME_LEN)) u_v_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (h_wrap),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  // Syncs and windows decode straight from the registered counters, so they
  // move on the same edge as the counters with no extra pipeline delay.
  assign hsync     = (h_cnt < H_SYNC);
  assign vsync     = (v_cnt < V_SYNC);
  assign v_act     = in_range(v_cnt, V_ACT_START, V_ACT_END);
  assign rgb_valid = v_act && in_range(h_cnt, H_ACT_START, H_ACT_END);
  assign pix_req   = v_act && in_range(h_cnt, H_REQ_START, H_REQ_END);

  assign pix_x = pix_req ? (h_cnt - H_REQ_START) : PIX_INVALID;
  assign pix_y = pix_req ? (v_cnt - V_ACT_START) : PIX_INVALID;
  assign rgb   = rgb_valid ? pix_data : RGB_BLACK;

  // Registered from the last pixel of the frame, so it is high while the
  // counters are at (0,0). Reset leaves it low, hence no pulse for the
  // frame that starts at reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_CTRL_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 8'd0;
    end else if (v_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: self-checking bench for vga_ctrl.
// Instance u_dut_a uses the default 640x480 timing for reset, line-level
// pixel/sync/gating behaviour and a mid-frame reset. Instance u_dut_b uses
// a tiny 17x10 raster (170-cycle frame) so frame-level behaviour (vsync
// width, frame_start period, reset at frame edges, frame_cnt wrap) can be
// exercised in a short run. Expected values come from cycle-count models.
// Define VGA_CTRL_FRAME_CNT_EN to include the frame_cnt checks.
module tb_vga_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [15:0] pix_data_a = 16'hcf59;
  logic [15:0] pix_data_b = 16'hcf59;

  logic [9:0]  pix_x_a, pix_y_a, pix_x_b, pix_y_b;
  logic        hsync_a, vsync_a, hsync_b, vsync_b;
  logic [15:0] rgb_a, rgb_b;
  logic        frame_start_a, frame_start_b;
`ifdef VGA_CTRL_FRAME_CNT_EN
  logic [7:0]  frame_cnt_a, frame_cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_a    = 0;   // cycles since last reset release of u_dut_a
  int cyc_b    = 0;
  logic pat_mode = 1'b0;
  logic [15:0] exp_q[$];

  vga_ctrl u_dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .pix_data    (pix_data_a),
    .pix_x       (pix_x_a),
    .pix_y       (pix_y_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .rgb         (rgb_a),
    .frame_start (frame_start_a)
`ifdef VGA_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt_a)
`endif
  );

  vga_ctrl #(
    .H_SYNC(10'd4), .H_BACK(10'd3), .H_VALID(10'd8), .H_FRONT(10'd2),
    .V_SYNC(10'd2), .V_BACK(10'd2), .V_VALID(10'd5), .V_FRONT(10'd1)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .pix_data    (pix_data_b),
    .pix_x       (pix_x_b),
    .pix_y       (pix_y_b),
    .hsync       (hsync_b),
    .vsync       (vsync_b),
    .rgb         (rgb_b),
    .frame_start (frame_start_b)
`ifdef VGA_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt_b)
`endif
  );

  // ---------------- driver tasks ----------------
  // Advance u_dut_a by n cycles, acting as the image generator: the pixel
  // for the coordinate seen before the edge is returned just after it.
  task automatic adv_a(input int n);
    for (int i = 0; i < n; i++) begin
      logic [9:0] px;
      logic [9:0] py;
      px = pix_x_a;
      py = pix_y_a;
      @(posedge clk);
      #1;
      if (pat_mode) pix_data_a = (px != 10'h3ff) ? {py[5:0], px} : 16'hdead;
      else          pix_data_a = 16'hcf59;
      cyc_a++;
      @(negedge clk);
    end
  endtask

  task automatic adv_b(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc_b++;
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge clk);
    rst_a = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    cyc_a = 0;
    n_checks++; if (hsync_a !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b expected 1", hsync_a); end
    n_checks++; if (vsync_a !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b expected 1", vsync_a); end
    n_checks++; if (pix_x_a !== 10'h3ff) begin n_fail++; $display("FAIL reset_pix_x: got %h expected 3ff", pix_x_a); end
    n_checks++; if (pix_y_a !== 10'h3ff) begin n_fail++; $display("FAIL reset_pix_y: got %h expected 3ff", pix_y_a); end
    n_checks++; if (rgb_a !== 16'h0) begin n_fail++; $display("FAIL reset_rgb: got %h expected 0000", rgb_a); end
    n_checks++; if (frame_start_a !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b expected 0", frame_start_a); end
`ifdef VGA_CTRL_FRAME_CNT_EN
    n_checks++; if (frame_cnt_a !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt_a); end
`endif
  endtask

  // Constant pixel data: rgb only inside the active window, lines 34/35.
  task automatic test_rgb_gate;
    int h, v;
    logic [15:0] exp_rgb;
    pat_mode = 1'b0;
    adv_a(34 * 800 - cyc_a);
    for (int i = 0; i < 1600; i++) begin
      h = cyc_a % 800;
      v = (cyc_a / 800) % 525;
      exp_rgb = (v >= 35 && v <= 514 && h >= 144 && h <= 783) ? 16'hcf59 : 16'h0000;
      n_checks++;
      if (rgb_a !== exp_rgb) begin
        n_fail++; $display("FAIL rgb_gate h=%0d v=%0d: got %h expected %h", h, v, rgb_a, exp_rgb);
      end
      n_checks++;
      if (frame_start_a !== 1'b0) begin
        n_fail++; $display("FAIL rgb_gate_frame_start h=%0d v=%0d: got %b expected 0", h, v, frame_start_a);
      end
      adv_a(1);
    end
  endtask

  // Pattern pixel data: coordinates, sync and 1-cycle latency via scoreboard.
  task automatic test_pixel_coords;
    int h, v, hs_cnt;
    logic req, vld;
    logic [9:0] exp_x, exp_y;
    logic [15:0] exp_rgb;
    pat_mode = 1'b1;
    exp_q.delete();
    hs_cnt = 0;
    adv_a(40 * 800 - cyc_a);
    for (int i = 0; i < 1600; i++) begin
      h = cyc_a % 800;
      v = (cyc_a / 800) % 525;
      req = (v >= 35 && v <= 514 && h >= 143 && h <= 782);
      vld = (v >= 35 && v <= 514 && h >= 144 && h <= 783);
      exp_x = req ? 10'(h - 143) : 10'h3ff;
      exp_y = req ? 10'(v - 35) : 10'h3ff;
      n_checks++;
      if (pix_x_a !== exp_x) begin n_fail++; $display("FAIL pix_x h=%0d v=%0d: got %h expected %h", h, v, pix_x_a, exp_x); end
      n_checks++;
      if (pix_y_a !== exp_y) begin n_fail++; $display("FAIL pix_y h=%0d v=%0d: got %h expected %h", h, v, pix_y_a, exp_y); end
      n_checks++;
      if (hsync_a !== (h < 96)) begin n_fail++; $display("FAIL hsync h=%0d: got %b expected %b", h, hsync_a, (h < 96)); end
      n_checks++;
      if (vsync_a !== 1'b0) begin n_fail++; $display("FAIL vsync_line v=%0d: got %b expected 0", v, vsync_a); end
      if (hsync_a === 1'b1) hs_cnt++;
      if (req) exp_q.push_back({exp_y[5:0], exp_x});
      if (vld) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sb_underflow h=%0d v=%0d: got %h expected queued pixel", h, v, rgb_a);
        end else begin
          exp_rgb = exp_q.pop_front();
          if (rgb_a !== exp_rgb) begin n_fail++; $display("FAIL sb_rgb h=%0d v=%0d: got %h expected %h", h, v, rgb_a, exp_rgb); end
        end
      end else begin
        n_checks++;
        if (rgb_a !== 16'h0) begin n_fail++; $display("FAIL rgb_blank h=%0d v=%0d: got %h expected 0000", h, v, rgb_a); end
      end
      if (h == 799) begin
        n_checks++;
        if (hs_cnt != 96) begin n_fail++; $display("FAIL hsync_width v=%0d: got %0d expected 96", v, hs_cnt); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover v=%0d: got %0d expected 0", v, exp_q.size()); end
        hs_cnt = 0;
      end
      adv_a(1);
    end
  endtask

  // One-cycle reset mid-line on the full-size raster.
  task automatic test_mid_reset_a;
    adv_a(500);   // now h=500 on line 42, pixels being requested
    rst_a = 1'b1;
    adv_a(1);
    rst_a = 1'b0;
    cyc_a = 0;
    n_checks++; if (pix_x_a !== 10'h3ff) begin n_fail++; $display("FAIL midrst_pix_x: got %h expected 3ff", pix_x_a); end
    n_checks++; if (pix_y_a !== 10'h3ff) begin n_fail++; $display("FAIL midrst_pix_y: got %h expected 3ff", pix_y_a); end
    n_checks++; if (rgb_a !== 16'h0) begin n_fail++; $display("FAIL midrst_rgb: got %h expected 0000", rgb_a); end
    n_checks++; if (hsync_a !== 1'b1) begin n_fail++; $display("FAIL midrst_hsync: got %b expected 1", hsync_a); end
    n_checks++; if (vsync_a !== 1'b1) begin n_fail++; $display("FAIL midrst_vsync: got %b expected 1", vsync_a); end
    n_checks++; if (frame_start_a !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_start: got %b expected 0", frame_start_a); end
  endtask

  // Two full frames on the small raster, every output modelled per cycle.
  task automatic test_frames_b;
    int h, v, vs_cnt, fs_cnt;
    logic req, vld, exp_fs;
    logic [9:0] exp_x, exp_y;
    logic [15:0] exp_rgb;
    vs_cnt = 0;
    fs_cnt = 0;
    @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    cyc_b = 0;
    for (int i = 0; i <= 340; i++) begin
      h = cyc_b % 17;
      v = (cyc_b / 17) % 10;
      req = (v >= 4 && v <= 8 && h >= 6 && h <= 13);
      vld = (v >= 4 && v <= 8 && h >= 7 && h <= 14);
      exp_x = req ? 10'(h - 6) : 10'h3ff;
      exp_y = req ? 10'(v - 4) : 10'h3ff;
      exp_rgb = vld ? 16'hcf59 : 16'h0000;
      exp_fs = (cyc_b != 0) && (cyc_b % 170 == 0);
      n_checks++;
      if (frame_start_b !== exp_fs) begin n_fail++; $display("FAIL b_frame_start cyc=%0d: got %b expected %b", cyc_b, frame_start_b, exp_fs); end
      n_checks++;
      if (vsync_b !== (v < 2)) begin n_fail++; $display("FAIL b_vsync cyc=%0d: got %b expected %b", cyc_b, vsync_b, (v < 2)); end
      n_checks++;
      if (hsync_b !== (h < 4)) begin n_fail++; $display("FAIL b_hsync cyc=%0d: got %b expected %b", cyc_b, hsync_b, (h < 4)); end
      n_checks++;
      if (rgb_b !== exp_rgb) begin n_fail++; $display("FAIL b_rgb h=%0d v=%0d: got %h expected %h", h, v, rgb_b, exp_rgb); end
      n_checks++;
      if (pix_x_b !== exp_x) begin n_fail++; $display("FAIL b_pix_x h=%0d v=%0d: got %h expected %h", h, v, pix_x_b, exp_x); end
      n_checks++;
      if (pix_y_b !== exp_y) begin n_fail++; $display("FAIL b_pix_y h=%0d v=%0d: got %h expected %h", h, v, pix_y_b, exp_y); end
`ifdef VGA_CTRL_FRAME_CNT_EN
      n_checks++;
      if (frame_cnt_b !== 8'(cyc_b / 170)) begin n_fail++; $display("FAIL b_frame_cnt cyc=%0d: got %0d expected %0d", cyc_b, frame_cnt_b, cyc_b / 170); end
`endif
      if (vsync_b === 1'b1) vs_cnt++;
      if (frame_start_b === 1'b1) fs_cnt++;
      if (cyc_b % 170 == 169) begin
        n_checks++;
        if (vs_cnt != 34) begin n_fail++; $display("FAIL b_vsync_width cyc=%0d: got %0d expected 34", cyc_b, vs_cnt); end
        vs_cnt = 0;
      end
      if (i != 340) adv_b(1);
    end
    n_checks++;
    if (fs_cnt != 2) begin n_fail++; $display("FAIL b_frame_start_count: got %0d expected 2", fs_cnt); end
  endtask

  // Reset mid-frame and on the last pixel of a frame: no pulse follows.
  task automatic test_mid_reset_b;
    logic exp_fs;
    adv_b(95);   // h=10, v=5 of the third frame
    rst_b = 1'b1;
    adv_b(1);
    rst_b = 1'b0;
    cyc_b = 0;
    n_checks++; if (pix_x_b !== 10'h3ff) begin n_fail++; $display("FAIL b_midrst_pix_x: got %h expected 3ff", pix_x_b); end
    n_checks++; if (rgb_b !== 16'h0) begin n_fail++; $display("FAIL b_midrst_rgb: got %h expected 0000", rgb_b); end
    for (int i = 0; i <= 170; i++) begin
      exp_fs = (cyc_b == 170);
      n_checks++;
      if (frame_start_b !== exp_fs) begin n_fail++; $display("FAIL b_midrst_frame_start cyc=%0d: got %b expected %b", cyc_b, frame_start_b, exp_fs); end
`ifdef VGA_CTRL_FRAME_CNT_EN
      n_checks++;
      if (frame_cnt_b !== 8'(cyc_b / 170)) begin n_fail++; $display("FAIL b_midrst_frame_cnt cyc=%0d: got %0d expected %0d", cyc_b, frame_cnt_b, cyc_b / 170); end
`endif
      if (i != 170) adv_b(1);
    end
    adv_b(169);  // last pixel of the frame (h=16, v=9)
    rst_b = 1'b1;
    adv_b(1);
    rst_b = 1'b0;
    cyc_b = 0;
    n_checks++; if (frame_start_b !== 1'b0) begin n_fail++; $display("FAIL b_edge_rst_frame_start: got %b expected 0", frame_start_b); end
    n_checks++; if (hsync_b !== 1'b1 || vsync_b !== 1'b1) begin n_fail++; $display("FAIL b_edge_rst_sync: got %b%b expected 11", hsync_b, vsync_b); end
  endtask

`ifdef VGA_CTRL_FRAME_CNT_EN
  // 256 frames from reset: frame_cnt passes 255 and wraps to 0.
  task automatic test_frame_cnt_wrap;
    for (int f = 1; f <= 256; f++) begin
      adv_b(170);
      n_checks++;
      if (frame_start_b !== 1'b1) begin n_fail++; $display("FAIL wrap_frame_start f=%0d: got %b expected 1", f, frame_start_b); end
      n_checks++;
      if (frame_cnt_b !== 8'(f)) begin n_fail++; $display("FAIL wrap_frame_cnt f=%0d: got %0d expected %0d", f, frame_cnt_b, f % 256); end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rgb_gate();
    test_pixel_coords();
    test_mid_reset_a();
    test_frames_b();
    test_mid_reset_b();
`ifdef VGA_CTRL_FRAME_CNT_EN
    test_frame_cnt_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_ctrl.md
# vga_ctrl

VGA timing generator for 640x480@60 Hz at a 25 MHz pixel clock. It owns the horizontal and vertical scan counters and drives hsync/vsync. It issues pixel coordinates (pix_x, pix_y) one cycle ahead of the visible region to the downstream image generator. It gates the returned pix_data onto the rgb output during active video.

## Interface
- H_SYNC, 10'd96, hsync pulse width in pixels
- H_BACK, 10'd48, horizontal back porch
- H_VALID, 10'd640, active pixels per line
- H_FRONT, 10'd16, horizontal front porch
- V_SYNC, 10'd2, vsync pulse width in lines
- V_BACK, 10'd33, vertical back porch
- V_VALID, 10'd480, active lines per frame
- V_FRONT, 10'd10, vertical front porch
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  reset, synchronous, active-high; the block has one clock, and reset is synchronous and active-high
- pix_data  in  16  RGB565 pixel from the image generator, registered there one cycle after pix_x/pix_y
- pix_x  out  10  requested column 0..639, 10'h3ff when no request
- pix_y  out  10  requested row 0..479, 10'h3ff when no request
- hsync  out  1  horizontal sync, active-high pulse
- vsync  out  1  vertical sync, active-high pulse
- rgb  out  16  displayed pixel, 16'd0 outside active video
- frame_start  out  1  one-cycle pulse when the counters wrap to (0,0)

## Operation
- Totals: H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT = 800; V_TOTAL = 525.
- Counter h_cnt (10 bit):
  - counts 0..H_TOTAL-1;
  - wraps to 0 after H_TOTAL-1.
- Counter v_cnt (10 bit):
  - increments only when h_cnt = H_TOTAL-1;
  - wraps to 0 when v_cnt = V_TOTAL-1 and h_cnt = H_TOTAL-1.
- hsync = (h_cnt < H_SYNC); vsync = (v_cnt < V_SYNC). Both are decoded from the registered counters.
- rgb_valid: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID-1] = [144,783], and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID-1] = [35,514].
- pix_req: the same window shifted one cycle earlier horizontally, h_cnt in [143,782], with the same v_cnt window.
- pix_x = pix_req ? h_cnt-143 : 10'h3ff.
- pix_y = pix_req ? v_cnt-35 : 10'h3ff.
- Subtraction is 10-bit unsigned and never underflows inside the window.
- rgb = rgb_valid ? pix_data : 16'd0.
- frame_start register:
  - set to 1 when (h_cnt, v_cnt) = (H_TOTAL-1, V_TOTAL-1);
  - otherwise set to 0.
- Reset state:
  - h_cnt = 0, v_cnt = 0, frame_start = 0;
  - therefore hsync = 1, vsync = 1, pix_x = pix_y = 10'h3ff, rgb = 0.
- Mid-frame reset: counters return to (0,0) on the next edge. No partial-frame flush is required.
- The first frame after reset release has no frame_start pulse. The first pulse occurs 420000 cycles after release.

## Timing
- Coordinate-to-pixel latency is 1 cycle. pix_x = 0 is presented at h_cnt = 143, and the matching pix_data is gated to rgb at h_cnt = 144.
- The last request is pix_x = 639 at h_cnt = 782. rgb_valid ends after h_cnt = 783.
- hsync and vsync change in the same cycle as the counter edge. There is no additional pipeline delay on sync relative to rgb.
- frame_start is high during the cycle in which h_cnt = 0 and v_cnt = 0.
- Line period is 800 cycles; frame period is 420000 cycles.

## Configuration
- VGA_CTRL_FRAME_CNT_EN
  - Defined: adds output frame_cnt, 8 bit. It resets to 0, increments in the same cycle frame_start is set, and wraps 255 to 0.
  - Undefined: the port and its register are absent, and all other behaviour is identical.

## Structure
- Package vga_pkg holds:
  - the default timing constants, plus H_TOTAL and V_TOTAL;
  - PIX_INVALID = 10'h3ff;
  - RGB565 color constants shared with the image generator.
- One sub-module, vga_scan_cnt: a parameterised modulo-N counter with enable and a wrap flag. It is instantiated twice, horizontal with enable 1 and vertical with enable from the horizontal wrap.

## Test plan
- Reset held 5 cycles, then released -> hsync = 1, vsync = 1, pix_x = pix_y = 3ff, rgb = 0, frame_start = 0.
- Run 2 full lines with v_cnt = 40 -> pix_x = 0 at h_cnt = 143 and 639 at h_cnt = 782; otherwise 3ff. pix_y = 5 inside the window. hsync high exactly 96 cycles per 800.
- Drive pix_data = 16'hCF59 constant -> rgb = CF59 only at h_cnt 144..783 on lines 35..514, and 0 elsewhere, including all of line 34 and line 515.
- Run 2 full frames -> vsync high for 1600 cycles per frame; frame_start pulses exactly once per 420000 cycles; frame_cnt (macro on) reads 1 then 2.
- Assert rst for 1 cycle at h_cnt = 500, v_cnt = 200 -> next cycle counters are (0,0), pix_x = 3ff, rgb = 0; no frame_start until the subsequent full frame.
- frame_cnt at 255 followed by a frame_start -> frame_cnt = 0 (macro on); with the macro off, the build has no frame_cnt port.
